nq_result_reporter: RTL and testbench

Downstream stage of the N-Queens parallel solver array. Watches the array's reduced 64-bit solution `sum` and global `done`, measures elapsed clock cycles from reset release to completion, and captures both values once. It then streams them out as a byte-wide framed packet over a valid/ready interface toward a host link such as a UART TX or a debug FIFO.

---
 rtl/nq_result_reporter.sv | 152 +++++++++++++++
 tb/tb_nq_result_reporter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/nq_result_reporter.sv
// nq_result_reporter
// Measures cycles from reset release until the solver array's `done` rises,
// captures `sum` and the cycle count once, then streams them out as a framed
// byte packet over valid/ready: 0xA5, result[7:0]..result[63:56], cycles LE,
// and an optional trailing XOR checksum byte.
// Optional feature macro: NQ_REPORT_CHECKSUM_EN (adds the checksum byte).
module nq_result_reporter #(
    parameter int CYCLE_W = 48
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [63:0]        sum,
    input  logic               done,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [63:0]        result,
    output logic [CYCLE_W-1:0] cycles,
    output logic               result_valid,
    output logic               busy
);

    localparam int CYC_BYTES = CYCLE_W / 8;
`ifdef NQ_REPORT_CHECKSUM_EN
    localparam int CHK_BYTES = 1;
`else
    localparam int CHK_BYTES = 0;
`endif
    localparam int FRAME_LEN = 1 + 8 + CYC_BYTES + CHK_BYTES;
    localparam int IDX_W     = 5;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_SEND = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CYCLE_W-1:0] r_cnt;
    logic               r_done_q;
    logic [IDX_W-1:0]   r_idx;
    logic [63:0]        r_result;
    logic [CYCLE_W-1:0] r_cycles;
    logic               r_result_valid;

    logic               w_capture;
    logic               w_fire;
    logic               w_last;
    logic [7:0]         w_tx_data;
    logic [7:0]         w_frame [FRAME_LEN];

    // Capture only on a rising edge of done while still measuring
    assign w_capture = (r_state == S_RUN) & done & ~r_done_q;
    assign w_fire    = (r_state == S_SEND) & tx_ready;
    assign w_last    = (r_idx == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: RUN until capture, SEND until last byte accepted, then HOLD forever
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN:   if (w_capture) w_state_next = S_SEND;
            S_SEND:  if (w_fire && w_last) w_state_next = S_HOLD;
            S_HOLD:  w_state_next = S_HOLD;
            default: w_state_next = S_RUN;
        endcase
    end

    // Cycle counter, done history, capture registers and byte index
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt          <= '0;
            r_done_q       <= 1'b0;
            r_idx          <= '0;
            r_result       <= '0;
            r_cycles       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_done_q <= done;
            // Saturating count; the value before this edge's increment is what gets captured
            if (r_cnt != {CYCLE_W{1'b1}}) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_capture) begin
                r_result       <= sum;
                r_cycles       <= r_cnt;
                r_result_valid <= 1'b1;
                r_idx          <= '0;
            end else if (w_fire) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Frame byte table built purely from captured registers, so tx_data is stable under backpressure
    assign w_frame[0] = 8'hA5;
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_res_bytes
            assign w_frame[1 + gi] = r_result[gi*8 +: 8];
        end
        for (genvar gi = 0; gi < CYC_BYTES; gi++) begin : g_cyc_bytes
            assign w_frame[9 + gi] = r_cycles[gi*8 +: 8];
        end
    endgenerate

`ifdef NQ_REPORT_CHECKSUM_EN
    logic [7:0] w_chk;

    // XOR of every payload byte (header excluded)
    always_comb begin
        w_chk = 8'h00;
        for (int i = 0; i < 8; i++) begin
            w_chk = w_chk ^ r_result[i*8 +: 8];
        end
        for (int i = 0; i < CYC_BYTES; i++) begin
            w_chk = w_chk ^ r_cycles[i*8 +: 8];
        end
    end

    assign w_frame[FRAME_LEN-1] = w_chk;
`endif

    // Select the current frame byte; outside SEND the bus idles at zero
    always_comb begin
        w_tx_data = 8'h00;
        if (r_state == S_SEND) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                if (r_idx == IDX_W'(i)) begin
                    w_tx_data = w_frame[i];
                end
            end
        end
    end

    assign tx_data      = w_tx_data;
    assign tx_valid     = (r_state == S_SEND);
    assign busy         = (r_state == S_SEND);
    assign result       = r_result;
    assign cycles       = r_cycles;
    assign result_valid = r_result_valid;

endmodule

// File: tb/tb_nq_result_reporter.sv
// Testbench for nq_result_reporter: one DUT at CYCLE_W=48, one at CYCLE_W=8.
// Expected frames come from a byte-queue model of the packet format.
module tb_nq_result_reporter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a = 1'b1;
    logic        reset_b = 1'b1;
    logic        done    = 1'b0;
    logic        tx_ready = 1'b0;
    logic [63:0] sum     = 64'd0;
    bit          sel     = 1'b0;   // 0: DUT A (48-bit), 1: DUT B (8-bit)

    logic [7:0]  a_data, b_data;
    logic        a_valid, b_valid, a_rv, b_rv, a_busy, b_busy;
    logic [63:0] a_result, b_result;
    logic [47:0] a_cycles;
    logic [7:0]  b_cycles;

    nq_result_reporter #(.CYCLE_W(48)) u_dut_a (
        .clk(clk), .reset(reset_a), .sum(sum), .done(done),
        .tx_data(a_data), .tx_valid(a_valid), .tx_ready(tx_ready),
        .result(a_result), .cycles(a_cycles), .result_valid(a_rv), .busy(a_busy)
    );

    nq_result_reporter #(.CYCLE_W(8)) u_dut_b (
        .clk(clk), .reset(reset_b), .sum(sum), .done(done),
        .tx_data(b_data), .tx_valid(b_valid), .tx_ready(tx_ready),
        .result(b_result), .cycles(b_cycles), .result_valid(b_rv), .busy(b_busy)
    );

    logic [7:0]  m_data;
    logic        m_valid, m_rv, m_busy;
    logic [63:0] m_result, m_cycles;

    always_comb begin
        m_data   = sel ? b_data   : a_data;
        m_valid  = sel ? b_valid  : a_valid;
        m_rv     = sel ? b_rv     : a_rv;
        m_busy   = sel ? b_busy   : a_busy;
        m_result = sel ? b_result : a_result;
        m_cycles = sel ? 64'(b_cycles) : 64'(a_cycles);
    end

    int n_chk  = 0;
    int n_pass = 0;

    byte unsigned exp_q[$];
    byte unsigned got_q[$];
    logic [63:0]  exp_cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: cycles = (done edge number - 1) saturated to CYCLE_W bits; frame = A5, sum LE, cycles LE, [xor]
    function automatic void build_frame(input logic [63:0] s, input int n, input int cw);
        logic [63:0] cmax;
        logic [63:0] c;
        byte unsigned x;
        cmax = (cw == 64) ? {64{1'b1}} : ((64'd1 << cw) - 64'd1);
        c = 64'(n - 1);
        if (c > cmax) c = cmax;
        exp_cyc = c;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        x = 8'h00;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(byte'(s >> (8*i)));
            x ^= byte'(s >> (8*i));
        end
        for (int i = 0; i < cw/8; i++) begin
            exp_q.push_back(byte'(c >> (8*i)));
            x ^= byte'(c >> (8*i));
        end
`ifdef NQ_REPORT_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endfunction

    task automatic set_reset(input logic v);
        if (sel) reset_b = v;
        else     reset_a = v;
    endtask

    // Reset, release, raise done so it is first sampled on non-reset edge n, check the capture
    task automatic start_run(input logic [63:0] s, input int n);
        @(negedge clk);
        sum = s; done = 1'b0; tx_ready = 1'b0;
        set_reset(1'b1);
        @(negedge clk);
        @(negedge clk);
        check("rst_valid",  64'(m_valid), 64'd0);
        check("rst_busy",   64'(m_busy),  64'd0);
        check("rst_rv",     64'(m_rv),    64'd0);
        check("rst_result", m_result,     64'd0);
        check("rst_cycles", m_cycles,     64'd0);
        check("rst_data",   64'(m_data),  64'd0);
        set_reset(1'b0);
        if (n == 1) done = 1'b1;
        for (int k = 1; k < n; k++) begin
            @(negedge clk);
            if (k == n - 1) done = 1'b1;
        end
        @(negedge clk);
        build_frame(s, n, sel ? 8 : 48);
        check("cap_rv",     64'(m_rv),    64'd1);
        check("cap_valid",  64'(m_valid), 64'd1);
        check("cap_result", m_result,     s);
        check("cap_cycles", m_cycles,     exp_cyc);
    endtask

    // Collect up to max_bytes accepted bytes; mode 0 ready=1, 1 alternating from 0, 2 random
    task automatic send_frame(input int mode, input int max_bytes, output int ncyc);
        bit          r;
        bit          prev_hold;
        logic [7:0]  prev_data;
        got_q.delete();
        prev_hold = 1'b0;
        prev_data = 8'h00;
        ncyc = 0;
        for (int t = 0; t < 400 && got_q.size() < max_bytes; t++) begin
            if (prev_hold) begin
                check("hold_stable", 64'(m_data),  64'(prev_data));
                check("hold_valid",  64'(m_valid), 64'd1);
            end
            check("busy_eq_valid", 64'(m_busy), 64'(m_valid));
            case (mode)
                0:       r = 1'b1;
                1:       r = (t % 2) == 1;
                default: r = $urandom_range(0, 1) == 1;
            endcase
            tx_ready = r;
            if (m_valid) begin
                ncyc++;
                if (r) got_q.push_back(m_data);
            end
            prev_hold = m_valid & ~r;
            prev_data = m_data;
            @(negedge clk);
        end
        tx_ready = 1'b0;
    endtask

    task automatic full_run(input logic [63:0] s, input int n, input int mode);
        int ncyc;
        start_run(s, n);
        send_frame(mode, exp_q.size(), ncyc);
        check("end_valid", 64'(m_valid), 64'd0);
        check("end_busy",  64'(m_busy),  64'd0);
        check("end_rv",    64'(m_rv),    64'd1);
        check("frame_len", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("byte%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
        end
        if (mode == 0) check("cyc_ready1", 64'(ncyc), 64'(exp_q.size()));
        if (mode == 1) check("cyc_alt",    64'(ncyc), 64'(2 * exp_q.size()));
        $display("run sel=%0d sum=%0h done_edge=%0d mode=%0d cycles=%0h bytes=%0d valid_cycles=%0d",
                 sel, s, n, mode, m_cycles, got_q.size(), ncyc);
    endtask

    initial begin
        logic [63:0] s;
        logic [63:0] old_result;
        int          vcount;
        int          ncyc;

        sel = 1'b0;
        // Basic frame and backpressure
        full_run(64'd92, 101, 0);
        check("t1_cycles", m_cycles, 64'd100);
        full_run(64'd92, 101, 1);

        // Immediate done, then a second done edge must be ignored
        s = {$urandom, $urandom};
        full_run(s, 1, 0);
        check("t3_cycles", m_cycles, 64'd0);
        old_result = m_result;
        done = 1'b0;
        repeat (2) @(negedge clk);
        done = 1'b1;
        sum  = ~s;
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_valid) vcount++;
        end
        check("t3_no_refire", 64'(vcount), 64'd0);
        check("t3_result",    m_result,    old_result);
        $display("repeat-edge: valid_cycles=%0d result=%0h", vcount, m_result);

        // Reset after 5 accepted bytes, then a fresh run
        start_run({$urandom, $urandom}, 30);
        send_frame(0, 5, ncyc);
        set_reset(1'b1);
        @(negedge clk);
        check("t4_valid", 64'(m_valid), 64'd0);
        check("t4_rv",    64'(m_rv),    64'd0);
        check("t4_busy",  64'(m_busy),  64'd0);
        $display("mid-frame reset after %0d bytes", got_q.size());
        full_run(64'd2, 11, 0);
        check("t4_cycles", m_cycles, 64'd10);

        // Randomized runs with random backpressure
        for (int i = 0; i < 6; i++) begin
            full_run({$urandom, $urandom}, $urandom_range(1, 60), $urandom_range(0, 2));
        end

        // Saturation on the 8-bit counter instance
        reset_a = 1'b1;
        sel = 1'b1;
        full_run({$urandom, $urandom}, 300, 0);
        check("t5_cycles", m_cycles, 64'hFF);
        full_run({$urandom, $urandom}, $urandom_range(2, 40), 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
